// File: rtl/gfm_seq_ctrl.sv
// Sequencer for an N x N GF(2) outer-product MAC array: clear, stream K operand pairs, drain N rows.
// Optional abort input is enabled by defining GFM_SEQ_ABORT_EN.
module gfm_seq_ctrl #(
    parameter int unsigned N = 32
) (
    input  logic               clk,
    input  logic               reset,
`ifdef GFM_SEQ_ABORT_EN
    input  logic               abort,
`endif
    input  logic               start,
    input  logic [$clog2(N):0] cfg_k,
    output logic               busy,
    output logic               done,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [N-1:0]       op_col,
    input  logic [N-1:0]       op_row,
    output logic               mac_clk_en,
    output logic               mac_reset,
    output logic               mac_write_valid,
    output logic               mac_read_valid,
    output logic [N-1:0]       mac_col_a,
    output logic [N-1:0]       mac_row_b,
    input  logic [N-1:0]       mac_load_down,
    output logic [N-1:0]       res_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_last
);

    localparam int unsigned KW = $clog2(N) + 1;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [KW-1:0]   op_cnt;
    logic [KW-1:0]   k_eff;
    logic [CW-1:0]   beat_cnt;
    logic            abort_hit;
    logic            blocked;
    logic            wr_fire;
    logic            rd_fire;
    logic            op_last;
    logic            beat_last;

`ifdef GFM_SEQ_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Reset or abort suppresses every handshake so no transfer is half-accepted.
    assign blocked   = reset || abort_hit;
    assign op_last   = (op_cnt == KW'(k_eff - KW'(1)));
    assign beat_last = (beat_cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state      = state;
        wr_fire         = 1'b0;
        rd_fire         = 1'b0;
        busy            = (state != IDLE);
        done            = (state == FIN);
        op_ready        = 1'b0;
        res_valid       = 1'b0;
        res_last        = 1'b0;
        res_data        = '0;
        case (state)
            IDLE: begin
                if (start) next_state = CLEAR;
            end
            CLEAR: begin
                next_state = ACCUM;
            end
            ACCUM: begin
                op_ready = !blocked;
                wr_fire  = op_ready && op_valid;
                if (wr_fire && op_last) next_state = DRAIN;
            end
            DRAIN: begin
                res_valid = !blocked;
                rd_fire   = res_valid && res_ready;
                res_last  = res_valid && beat_last;
                res_data  = res_valid ? mac_load_down : '0;
                if (rd_fire && beat_last) next_state = FIN;
            end
            FIN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (abort_hit) next_state = IDLE;
        mac_write_valid = wr_fire;
        mac_read_valid  = rd_fire;
        mac_col_a       = wr_fire ? op_col : '0;
        mac_row_b       = wr_fire ? op_row : '0;
        mac_reset       = reset || (state == CLEAR) || abort_hit;
        mac_clk_en      = mac_reset || wr_fire || rd_fire;
    end

    // Operand/beat counters and the K latched on an accepted start (0 selects N).
    always_ff @(posedge clk) begin
        if (reset) begin
            op_cnt   <= '0;
            beat_cnt <= '0;
            k_eff    <= KW'(N);
        end else if (abort_hit) begin
            op_cnt   <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                k_eff    <= (cfg_k == '0) ? KW'(N) : cfg_k;
                op_cnt   <= '0;
                beat_cnt <= '0;
            end
            if (wr_fire) op_cnt <= op_last ? '0 : KW'(op_cnt + 1'b1);
            if (rd_fire) beat_cnt <= beat_last ? '0 : CW'(beat_cnt + 1'b1);
        end
    end

endmodule

// File: tb/tb_gfm_seq_ctrl.sv
// Directed bench for gfm_seq_ctrl (N=4) with a behavioural GF(2) MAC array and a result scoreboard.
// Abort scenario is compiled in when GFM_SEQ_ABORT_EN is defined.
`timescale 1ns/1ps
module tb_gfm_seq_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned KW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [KW-1:0] cfg_k;
    logic          busy;
    logic          done;
    logic          op_valid;
    logic          op_ready;
    logic [N-1:0]  op_col;
    logic [N-1:0]  op_row;
    logic          mac_clk_en;
    logic          mac_reset;
    logic          mac_write_valid;
    logic          mac_read_valid;
    logic [N-1:0]  mac_col_a;
    logic [N-1:0]  mac_row_b;
    logic [N-1:0]  mac_load_down;
    logic [N-1:0]  res_data;
    logic          res_valid;
    logic          res_ready;
    logic          res_last;
`ifdef GFM_SEQ_ABORT_EN
    logic          abort;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [N-1:0] a_col [N];
    logic [N-1:0] b_row [N];
    logic [N-1:0] exp_q [$];
    logic [N-1:0] acc   [N];

    always #5 clk = ~clk;

    gfm_seq_ctrl #(.N(N)) dut (
        .clk             (clk),
        .reset           (reset),
`ifdef GFM_SEQ_ABORT_EN
        .abort           (abort),
`endif
        .start           (start),
        .cfg_k           (cfg_k),
        .busy            (busy),
        .done            (done),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .op_col          (op_col),
        .op_row          (op_row),
        .mac_clk_en      (mac_clk_en),
        .mac_reset       (mac_reset),
        .mac_write_valid (mac_write_valid),
        .mac_read_valid  (mac_read_valid),
        .mac_col_a       (mac_col_a),
        .mac_row_b       (mac_row_b),
        .mac_load_down   (mac_load_down),
        .res_data        (res_data),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_last        (res_last)
    );

    // Behavioural array: row r accumulates row_b when col_a[r] is set; reads shift rows toward row N-1.
    always_ff @(posedge clk) begin
        if (mac_clk_en) begin
            if (mac_reset) begin
                for (int r = 0; r < N; r++) acc[r] <= '0;
            end else if (mac_write_valid) begin
                for (int r = 0; r < N; r++) if (mac_col_a[r]) acc[r] <= acc[r] ^ mac_row_b;
            end else if (mac_read_valid) begin
                for (int r = N - 1; r > 0; r--) acc[r] <= acc[r-1];
                acc[0] <= '0;
            end
        end
    end
    assign mac_load_down = acc[N-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int j = 0; j < N; j++) begin
            a_col[j] = N'($urandom);
            b_row[j] = N'($urandom);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_op_ready"}, 32'(op_ready), 0);
        chk({tag, "_res_valid"}, 32'(res_valid), 0);
        chk({tag, "_res_last"}, 32'(res_last), 0);
        chk({tag, "_wr"}, 32'(mac_write_valid), 0);
        chk({tag, "_rd"}, 32'(mac_read_valid), 0);
        chk({tag, "_col_a"}, 32'(mac_col_a), 0);
        chk({tag, "_row_b"}, 32'(mac_row_b), 0);
    endtask

    // One product: gap_mask bit t drops op_valid in ACCUM cycle t; stall_beat/stall_len hold res_ready low;
    // istart_at pulses an (ignored) start with cfg_k=1; rst_beat asserts reset in DRAIN at that beat.
    task automatic run_product(input int k_cfg, input int gap_mask, input int stall_beat, input int stall_len,
                               input int istart_at, input int rst_beat);
        int k, i, t, beat, stalls, wr_cnt;
        logic vld, rdy;
        logic [N-1:0] c [N];
        k = (k_cfg == 0) ? N : k_cfg;
        for (int r = 0; r < N; r++) begin
            c[r] = '0;
            for (int j = 0; j < k; j++) if (a_col[j][r]) c[r] = c[r] ^ b_row[j];
        end
        for (int r = N - 1; r >= 0; r--) exp_q.push_back(c[r]);

        cfg_k = KW'(k_cfg);
        start = 1'b1;
        #1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_mac_reset", 32'(mac_reset), 0);
        cyc();
        start = 1'b0;
        #1;
        chk("clr_mac_reset", 32'(mac_reset), 1);
        chk("clr_clk_en", 32'(mac_clk_en), 1);
        chk("clr_busy", 32'(busy), 1);
        chk("clr_op_ready", 32'(op_ready), 0);
        cyc();

        i = 0; t = 0; wr_cnt = 0;
        while (i < k && t < 64) begin
            vld      = ((gap_mask >> t) & 1) == 0;
            op_valid = vld;
            op_col   = a_col[i];
            op_row   = b_row[i];
            if (istart_at == t) begin
                start = 1'b1;
                cfg_k = KW'(1);
            end
            #1;
            chk("acc_op_ready", 32'(op_ready), 1);
            chk("acc_wr", 32'(mac_write_valid), 32'(vld));
            chk("acc_clk_en", 32'(mac_clk_en), 32'(vld));
            chk("acc_rd", 32'(mac_read_valid), 0);
            chk("acc_col_a", 32'(mac_col_a), vld ? 32'(a_col[i]) : 0);
            chk("acc_row_b", 32'(mac_row_b), vld ? 32'(b_row[i]) : 0);
            if (mac_write_valid) wr_cnt++;
            if (vld) i++;
            t++;
            cyc();
            start = 1'b0;
        end
        op_valid = 1'b0;
        chk("acc_transfers", 32'(i), 32'(k));
        chk("acc_wr_pulses", 32'(wr_cnt), 32'(k));

        beat = 0; stalls = 0; t = 0;
        while (beat < N && t < 64) begin
            rdy       = !(beat == stall_beat && stalls < stall_len);
            res_ready = rdy;
            if (rst_beat == beat) reset = 1'b1;
            #1;
            if (reset) begin
                chk("rst_mac_reset", 32'(mac_reset), 1);
                chk("rst_clk_en", 32'(mac_clk_en), 1);
                chk("rst_rd", 32'(mac_read_valid), 0);
                cyc();
                reset     = 1'b0;
                res_ready = 1'b0;
                #1;
                chk_idle_outputs("post_rst");
                chk("post_rst_mac_reset", 32'(mac_reset), 0);
                exp_q.delete();
                return;
            end
            chk("drn_res_valid", 32'(res_valid), 1);
            chk("drn_op_ready", 32'(op_ready), 0);
            chk("drn_rd", 32'(mac_read_valid), 32'(rdy));
            chk("drn_clk_en", 32'(mac_clk_en), 32'(rdy));
            chk("drn_wr", 32'(mac_write_valid), 0);
            chk("drn_res_data", 32'(res_data), 32'(exp_q[0]));
            chk("drn_res_last", 32'(res_last), 32'(beat == N - 1));
            if (rdy) begin
                void'(exp_q.pop_front());
                beat++;
            end else begin
                stalls++;
            end
            t++;
            cyc();
        end
        res_ready = 1'b0;
        chk("drn_beats", 32'(beat), 32'(N));
        #1;
        chk("fin_done", 32'(done), 1);
        chk("fin_busy", 32'(busy), 1);
        chk("fin_res_valid", 32'(res_valid), 0);
        cyc();
        #1;
        chk("end_done", 32'(done), 0);
        chk("end_busy", 32'(busy), 0);
    endtask

`ifdef GFM_SEQ_ABORT_EN
    // Abort raised together with start in IDLE (start wins), then again after two transfers.
    task automatic run_abort();
        cfg_k = '0;
        start = 1'b1;
        abort = 1'b1;
        #1;
        chk("ab_idle_mac_reset", 32'(mac_reset), 0);
        cyc();
        start = 1'b0;
        abort = 1'b0;
        #1;
        chk("ab_clr_busy", 32'(busy), 1);
        chk("ab_clr_mac_reset", 32'(mac_reset), 1);
        cyc();
        for (int j = 0; j < 2; j++) begin
            op_valid = 1'b1;
            op_col   = a_col[j];
            op_row   = b_row[j];
            #1;
            chk("ab_wr", 32'(mac_write_valid), 1);
            cyc();
        end
        abort = 1'b1;
        #1;
        chk("ab_mac_reset", 32'(mac_reset), 1);
        chk("ab_clk_en", 32'(mac_clk_en), 1);
        chk("ab_wr_blocked", 32'(mac_write_valid), 0);
        chk("ab_op_ready", 32'(op_ready), 0);
        cyc();
        abort    = 1'b0;
        op_valid = 1'b0;
        #1;
        chk_idle_outputs("post_ab");
        chk("post_ab_mac_reset", 32'(mac_reset), 0);
        cyc();
        #1;
        chk("post_ab_done2", 32'(done), 0);
    endtask
`endif

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        cfg_k     = '0;
        op_valid  = 1'b0;
        op_col    = '0;
        op_row    = '0;
        res_ready = 1'b0;
`ifdef GFM_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        cyc();
        cyc();
        chk("in_rst_mac_reset", 32'(mac_reset), 1);
        chk("in_rst_clk_en", 32'(mac_clk_en), 1);
        reset = 1'b0;
        #1;
        chk_idle_outputs("por");

        for (int j = 0; j < N; j++) begin
            a_col[j] = N'(1 << j);
            b_row[j] = N'(1 << j);
        end
        run_product(0, 0, -1, 0, -1, -1);

        fill_random();
        run_product(2, 32'b010, -1, 0, -1, -1);

        fill_random();
        run_product(0, 0, 1, 3, -1, -1);

        fill_random();
        run_product(3, 0, -1, 0, 1, -1);
        fill_random();
        run_product(1, 0, -1, 0, -1, -1);

        fill_random();
        run_product(0, 0, -1, 0, -1, 2);
        fill_random();
        run_product(4, 32'b1001, 0, 1, -1, -1);

`ifdef GFM_SEQ_ABORT_EN
        fill_random();
        run_abort();
        fill_random();
        run_product(0, 0, -1, 0, -1, -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gfm_seq_ctrl.md
GFM_SEQ_CTRL -- requirements
Module: gfm_seq_ctrl

Interface
REQ-001 Parameter: N, default 32, matrix dimension and bit width of the outer-product MAC array.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  one-cycle request to begin a product; honoured only in IDLE.
REQ-005 Port: cfg_k  in  $clog2(N)+1  inner dimension K (number of outer products); sampled on accepted start; 0 means N.
REQ-006 Port: busy  out  1  high in every state except IDLE.
REQ-007 Port: done  out  1  one-cycle pulse after the final result beat.
REQ-008 Port: op_valid / op_ready  in / out  1 / 1  operand stream handshake.
REQ-009 Port: op_col / op_row  in  N / N  column i of A and row i of B.
REQ-010 Port: mac_clk_en, mac_reset, mac_write_valid, mac_read_valid  out  1 each  MAC array controls.
REQ-011 Port: mac_col_a / mac_row_b  out  N / N  operands to the MAC array.
REQ-012 Port: mac_load_down  in  N  bottom row output of the MAC array.
REQ-013 Port: res_data / res_valid / res_ready / res_last  out N / out 1 / in 1 / out 1  result row stream.

Function
REQ-014 The FSM SHALL have the states IDLE, CLEAR, ACCUM, DRAIN and FIN.
- IDLE->CLEAR: on start.
- CLEAR->ACCUM: after exactly 1 cycle.
- ACCUM->DRAIN: on the K-th operand transfer.
- DRAIN->FIN: on the N-th result transfer.
- FIN->IDLE: after exactly 1 cycle.
REQ-015 In CLEAR, mac_reset and mac_clk_en SHALL both be high for one cycle to zero the accumulators.
REQ-016 In ACCUM, op_ready SHALL be 1; op_ready SHALL be 0 in every other state.
REQ-017 On each op_valid&&op_ready cycle, the block SHALL drive mac_write_valid=1, mac_clk_en=1, mac_col_a=op_col and mac_row_b=op_row combinationally (zero latency).
REQ-018 With no transfer, the block SHALL drive mac_write_valid=0, mac_clk_en=0 and both operand buses to 0 (accumulators hold).
REQ-019 The operand counter SHALL count 0..K-1; the transfer at count K-1 SHALL be the last one accepted, with no wrap.
REQ-020 In DRAIN, the block SHALL drive res_valid=1 and res_data=mac_load_down.
REQ-021 On res_valid&&res_ready, the block SHALL drive mac_read_valid=1 and mac_clk_en=1 for that cycle to shift the next row down.
REQ-022 When res_ready=0, mac_clk_en SHALL be 0, and res_data SHALL stay stable until the beat is accepted.
REQ-023 res_last SHALL be 1 only on beat N-1, counting beats from 0.
REQ-024 done SHALL be 1 only in FIN; busy SHALL be 0 only in IDLE.
REQ-025 A start while busy SHALL be ignored, and cfg_k SHALL be re-sampled only on an accepted start.
REQ-026 mac_write_valid and mac_read_valid SHALL never be high in the same cycle.
REQ-027 If op_valid stays low, ACCUM SHALL wait indefinitely with no timeout.

Reset
REQ-028 reset SHALL override all other inputs and, at the next edge, set the FSM to IDLE and both counters to 0.
REQ-029 After reset, the outputs SHALL be: busy=0, done=0, op_ready=0, res_valid=0, res_last=0, mac_write_valid=0, mac_read_valid=0, mac_col_a=0, mac_row_b=0.
REQ-030 mac_reset SHALL equal reset OR the CLEAR-state pulse, and mac_clk_en SHALL be 1 while reset is high, so that a mid-operation reset also clears the array.

Configuration
REQ-031 The macro GFM_SEQ_ABORT_EN SHALL control an abort feature, as follows.
- When defined: the block SHALL add input port abort (1 bit). Asserting abort in any non-IDLE state SHALL:
  - force mac_reset=1 and mac_clk_en=1 for that cycle;
  - discard in-flight work;
  - enter IDLE on the next edge without pulsing done.
  In IDLE, abort SHALL have no effect. If abort and start occur in the same IDLE cycle, start wins.
- When undefined: the block SHALL have no abort port, and the only ways to exit an operation SHALL be completion or reset.

Verification
REQ-032 Bench scenarios (N=4 bench unless stated):
- N=4, cfg_k=0, A=I, B rows {1,2,4,8}, op_valid held high, res_ready held high -> 4 ACCUM cycles, 4 beats equal to B in array order, res_last on beat 3, done 1 cycle later.
- cfg_k=2, op_valid toggling 1,0,1 -> exactly 2 mac_write_valid pulses, and mac_clk_en=0 in the gap cycle.
- DRAIN with res_ready low for 3 cycles before beat 1 -> res_data stable, mac_read_valid=0 and mac_clk_en=0 throughout the stall.
- start pulsed in ACCUM with cfg_k=1 -> ignored; the original K completes; a second start after done runs with cfg_k=1.
- reset asserted in DRAIN -> next cycle IDLE with all outputs at reset values, mac_reset seen high, and a following run returns correct results with no residue.
- With GFM_SEQ_ABORT_EN defined, abort in ACCUM after 2 transfers -> IDLE next cycle, no done pulse, and a subsequent product is correct.
